inst_mem_prog: RTL

//  Parametrised, loadable, synchronous instruction memory for the 10-bit CPU; replaces per-program hard-coded ROMs.

---
 rtl/inst_mem_prog.sv | 134 +++++++++++++
 1 files changed

// File: rtl/inst_mem_prog.sv
// Loadable synchronous instruction memory: valid/ready program load port, 1-cycle fetch port.
// Optional build macro INST_PARITY_EN adds a stored even-parity bit per word, checked on fetch.
module inst_mem_prog #(
    parameter int INST_W = 10,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [INST_W-1:0] load_data,
    input  logic              load_par,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   prog_len,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [INST_W-1:0] inst_out,
    output logic              inst_valid,
    output logic              halt_seen,
    output logic              parity_err
);

`ifdef INST_PARITY_EN
    localparam int MEM_W = INST_W + 1;

    function automatic logic evenPar(input logic [INST_W-1:0] word);
        return ^word;
    endfunction
`else
    localparam int MEM_W = INST_W;
    logic unusedPar;
    assign unusedPar = load_par;
`endif

    typedef enum logic [1:0] {EMPTY, LOAD, READY} stateT;

    stateT             state;
    logic [ADDR_W-1:0] wPtr;
    logic [MEM_W-1:0]  mem [DEPTH];

    logic              writeEn;
    logic              lastWord;
    logic              inRange;
    logic [MEM_W-1:0]  memWord;
    logic [MEM_W-1:0]  rdWord;
    logic [INST_W-1:0] fetchWord;
    logic              fetchPerr;

    // A word presented together with load_start is dropped: the restart takes priority.
    assign writeEn  = (state == LOAD) && load_valid && !load_start;
    assign lastWord = load_last || (wPtr == ADDR_W'(DEPTH - 1));
    assign inRange  = {1'b0, fetch_addr} < prog_len;
    assign rdWord   = mem[fetch_addr];

`ifdef INST_PARITY_EN
    assign memWord = {load_par, load_data};
`else
    assign memWord = load_data;
`endif

    always_ff @(posedge clk) begin
        if (writeEn)
            mem[wPtr] <= memWord;
    end

    // Out-of-range reads and parity failures both deliver the all-zero halt word.
    always_comb begin
        fetchWord = '0;
        fetchPerr = 1'b0;
        if (inRange) begin
            fetchWord = rdWord[INST_W-1:0];
`ifdef INST_PARITY_EN
            if (rdWord[INST_W] != evenPar(rdWord[INST_W-1:0])) begin
                fetchPerr = 1'b1;
                fetchWord = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            wPtr       <= '0;
            prog_len   <= '0;
            load_ready <= 1'b0;
            load_done  <= 1'b0;
            inst_out   <= '0;
            inst_valid <= 1'b0;
            halt_seen  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            load_done  <= 1'b0;
            inst_valid <= 1'b0;
            parity_err <= 1'b0;
            if (load_start) begin
                state      <= LOAD;
                load_ready <= 1'b1;
                wPtr       <= '0;
                prog_len   <= '0;
                halt_seen  <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        if (load_valid) begin
                            wPtr <= wPtr + 1'b1;
                            if (lastWord) begin
                                state      <= READY;
                                load_ready <= 1'b0;
                                load_done  <= 1'b1;
                                prog_len   <= {1'b0, wPtr} + 1'b1;
                            end
                        end
                    end
                    READY: begin
                        // fetch stage boundary: result registered one cycle after the request
                        if (fetch_req) begin
                            inst_valid <= 1'b1;
                            inst_out   <= fetchWord;
                            parity_err <= fetchPerr;
                            if (fetchWord[INST_W-1 -: 4] == 4'b0000)
                                halt_seen <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
